// File: rtl/seg_pkg.sv
// seg_pkg: shared state type, glyph table and digit count for the
// multiplexed 7-segment scan controller.
// Glyphs are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } seg_state_e;

    localparam int NUM_DIGITS = 4;

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index n holds the glyph for nibble n (0-9, then A b C d E F).
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_decode.sv
// seg_decode: nibble to active-low 7-segment glyph.
// Build option SEG_SCAN_HEX_EN: when defined, A-F show hex letters;
// otherwise A-F leave the digit dark.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup, with the non-decimal codes blanked in decimal-only builds.
    always_comb begin
`ifdef SEG_SCAN_HEX_EN
        seg_o = GLYPHS[nibble_i];
`else
        seg_o = (nibble_i <= 4'd9) ? GLYPHS[nibble_i] : SEG_OFF;
`endif
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scanner with a blanking
// window at the start of every digit slot and frame-aligned data loads.
// Build option SEG_SCAN_HEX_EN selects hex glyphs in seg_decode.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_BLANK | prescaler < BLANK_CYCLES, all digits off (anti-ghost)
//   ST_DRIVE | current digit enabled with its shadow glyph
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load_req,
    output logic        load_ack,
    output logic [3:0]  io_sel,
    output logic [7:0]  io_seg,
    output logic        frame_done
);

    localparam int              PW          = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END   = PW'(BLANK_CYCLES);
    localparam logic [1:0]      LAST_DIGIT  = 2'(NUM_DIGITS - 1);

    if (SCAN_DIV < 2 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
        $error("seg_scan_ctrl: need SCAN_DIV >= 2 and BLANK_CYCLES < SCAN_DIV");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic          presc_wrap;
    seg_state_e    state_q, state_d;
    logic [15:0]   shadow_val_q, shadow_val_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic          capture;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic [3:0]    sel_q;
    logic [7:0]    seg_q;
    logic          ack_q;
    logic          frame_done_q;

    // Prescaler and digit index advance; index steps on every prescaler wrap.
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d      = presc_wrap ? idx_q + 2'd1 : idx_q;
    end

    // frame_done_q marks the frame boundary cycle, so a load requested there
    // lands exactly as digit 0 of the new frame is computed. Decoding from the
    // next-state shadow keeps the whole new frame on the new data even when
    // the blanking window is zero.
    always_comb begin
        capture      = frame_done_q & load_req;
        shadow_val_d = capture ? value_in : shadow_val_q;
        shadow_dp_d  = capture ? dp_in : shadow_dp_q;
        nibble       = shadow_val_d[{idx_q, 2'b00} +: 4];
    end

    // Blank/drive decision from the current prescaler position.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (presc_q >= BLANK_END) state_d = ST_DRIVE;
            ST_DRIVE: if (presc_q <  BLANK_END) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

    seg_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // Scan counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // FSM, shadow registers and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            sel_q        <= 4'b0000;
            seg_q        <= 8'hFF;
            ack_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            ack_q        <= capture;
            frame_done_q <= presc_wrap && (idx_q == LAST_DIGIT);
            if (state_d == ST_DRIVE) begin
                sel_q <= 4'b0001 << idx_q;
                seg_q <= {~shadow_dp_d[idx_q], glyph};
            end else begin
                sel_q <= 4'b0000;
                seg_q <= 8'hFF;
            end
        end
    end

    assign io_sel     = sel_q;
    assign io_seg     = seg_q;
    assign load_ack   = ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV = 8, BLANK_CYCLES = 2.
// Reference model: outputs after the n-th clock edge since reset release
// follow from n alone (slot position n mod 8, digit (n div 8) mod 4) plus
// the data captured at the most recent frame boundary.
module tb_seg_scan_ctrl;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = SD * 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in    = 4'h0;
    logic        load_req = 1'b0;
    logic        load_ack;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          k         = 0;
    int          m_p       = 0;
    int          m_i       = 0;
    logic [15:0] m_val     = 16'h0000;
    logic [3:0]  m_dp      = 4'h0;
    logic        m_fd_prev = 1'b0;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic [3:0][7:0] seg;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .io_sel     (io_sel),
        .io_seg     (io_seg),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
`ifdef SEG_SCAN_HEX_EN
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
`else
            default: return 7'h7F;
`endif
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"},   io_sel,     4'b0000);
        chk({tag, "_seg"},   io_seg,     8'hFF);
        chk({tag, "_ack"},   load_ack,   1'b0);
        chk({tag, "_frame"}, frame_done, 1'b0);
    endtask

    task automatic reset_model();
        k         = 0;
        m_val     = 16'h0000;
        m_dp      = 4'h0;
        m_fd_prev = 1'b0;
    endtask

    // One clock edge, then compare every output with the model.
    task automatic step();
        logic        req_s;
        logic [15:0] val_s;
        logic [3:0]  dp_s;
        logic        cap;
        logic        e_fd;
        logic [3:0]  e_sel;
        logic [7:0]  e_seg;
        int          c;
        req_s = load_req;
        val_s = value_in;
        dp_s  = dp_in;
        @(posedge clk);
        #1;
        c   = k;
        k++;
        m_p = c % SD;
        m_i = (c / SD) % 4;
        cap = m_fd_prev && req_s;
        if (cap) begin
            m_val = val_s;
            m_dp  = dp_s;
        end
        e_fd = (m_p == SD - 1) && (m_i == 3);
        if (m_p < BC) begin
            e_sel = 4'b0000;
            e_seg = 8'hFF;
        end else begin
            e_sel = 4'b0001 << m_i;
            e_seg = {~m_dp[m_i], ref_glyph(m_val[m_i*4 +: 4])};
        end
        m_fd_prev = e_fd;
        chk("io_sel",     io_sel,     e_sel);
        chk("io_seg",     io_seg,     e_seg);
        chk("frame_done", frame_done, e_fd);
        chk("load_ack",   load_ack,   cap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit hit;
        int ack_cnt;
        int ack_at [$];

        tbl[0].val = 16'h4321; tbl[0].dp = 4'b0001; tbl[0].seg = {8'h99, 8'hB0, 8'hA4, 8'h79};
        tbl[1].val = 16'h8765; tbl[1].dp = 4'b1010; tbl[1].seg = {8'h00, 8'hF8, 8'h02, 8'h92};
        tbl[2].val = 16'h0009; tbl[2].dp = 4'b0000; tbl[2].seg = {8'hC0, 8'hC0, 8'hC0, 8'h90};
`ifdef SEG_SCAN_HEX_EN
        tbl[3].val = 16'hFEDC; tbl[3].dp = 4'b0100; tbl[3].seg = {8'h8E, 8'h06, 8'hA1, 8'hC6};
`else
        tbl[3].val = 16'hFEDC; tbl[3].dp = 4'b0100; tbl[3].seg = {8'hFF, 8'h7F, 8'hFF, 8'hFF};
`endif

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1 chk_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();

        // Plain scan sequence with all-zero shadow data.
        repeat (2 * FRAME) step();

        // Table vectors: load at a boundary, then check the following frame.
        for (int v = 0; v < 4; v++) begin
            value_in = tbl[v].val;
            dp_in    = tbl[v].dp;
            load_req = 1'b1;
            found    = 1'b0;
            for (int n = 0; n < FRAME + 2 && !found; n++) begin
                step();
                if (load_ack === 1'b1) found = 1'b1;
            end
            load_req = 1'b0;
            chk("vec_ack_seen", found, 1'b1);
            for (int n = 0; n < FRAME - 1; n++) begin
                step();
                if (m_p >= BC) chk("vec_seg", io_seg, tbl[v].seg[m_i]);
            end
        end

        // Input changes without a request must not reach the display.
        ack_cnt = 0;
        repeat (13) step();
        value_in = 16'h9999;
        dp_in    = 4'hF;
        repeat (2 * FRAME) begin
            step();
            if (load_ack === 1'b1) ack_cnt++;
        end
        chk("no_req_acks", ack_cnt, 0);

        // Request held across two boundaries: two acks, one frame apart.
        found = 1'b0;
        for (int n = 0; n < FRAME + 1 && !found; n++) begin
            step();
            if (frame_done === 1'b1) found = 1'b1;
        end
        chk("boundary_seen", found, 1'b1);
        value_in = 16'h1357;
        dp_in    = 4'b1000;
        load_req = 1'b1;
        for (int n = 0; n < 2 * FRAME; n++) begin
            step();
            if (load_ack === 1'b1) ack_at.push_back(k);
        end
        load_req = 1'b0;
        chk("two_acks", ack_at.size(), 2);
        if (ack_at.size() == 2) chk("ack_spacing", ack_at[1] - ack_at[0], FRAME);
        repeat (FRAME + 4) step();

        // Randomised inputs.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) value_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dp_in = 4'($urandom);
            load_req = ($urandom_range(0, 2) != 0);
            step();
        end
        load_req = 1'b0;

        // Reset during digit 2 drive with a pending request.
        hit = 1'b0;
        for (int n = 0; n < FRAME + 1 && !hit; n++) begin
            step();
            if (m_i == 2 && m_p == 4) hit = 1'b1;
        end
        chk("reach_digit2", hit, 1'b1);
        value_in = 16'hABCD;
        dp_in    = 4'hF;
        load_req = 1'b1;
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("held_rst");
        rst = 1'b0;
        reset_model();
        repeat (FRAME + 8) step();
        load_req = 1'b0;
        repeat (FRAME) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, meaning clock cycles per digit slot (1 ms frame at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, meaning the blanked cycles at the start of each slot (anti-ghosting).
REQ-003 SHALL have port clk, input, 1, meaning the single design clock (all state on posedge).
REQ-004 SHALL have port rst, input, 1, meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port value_in, input, 16, meaning the four nibbles to display (digit 0 = bits 3:0).
REQ-006 SHALL have port dp_in, input, 4, meaning the decimal point request per digit (1 = lit).
REQ-007 SHALL have port load_req, input, 1, meaning the requester asks for value_in/dp_in to be captured.
REQ-008 SHALL have port load_ack, output, 1, meaning a one-cycle pulse that a capture occurred.
REQ-009 SHALL have port io_sel, output, 4, meaning the one-hot active-high digit enable.
REQ-010 SHALL have port io_seg, output, 8, meaning the segments active-low, bit 7 = dp, bits 6:0 = g..a.
REQ-011 SHALL have port frame_done, output, 1, meaning a one-cycle pulse on the last cycle of digit 3's slot.

Function
REQ-012 SHALL keep a prescaler counting 0..SCAN_DIV-1, wrapping to 0, with the 2-bit digit index incrementing (3 wraps to 0) on each wrap.
REQ-013 SHALL implement FSM states BLANK and DRIVE: BLANK while prescaler < BLANK_CYCLES, DRIVE otherwise; BLANK is re-entered on every prescaler wrap.
REQ-014 In BLANK, io_sel SHALL be 4'b0000 and io_seg SHALL be 8'hFF.
REQ-015 In DRIVE, io_sel SHALL be 1 << digit index and io_seg SHALL be the decoded shadow nibble, with bit 7 = ~shadow_dp[index].
REQ-016 All outputs SHALL be registered, reflecting state with exactly 1 cycle latency from the prescaler/index values.
REQ-017 SHALL capture value_in/dp_in into shadow registers only at the frame boundary (last cycle of digit 3 slot) while load_req = 1; load_ack SHALL be high for exactly the following cycle.
REQ-018 With load_req = 0 at the boundary, shadow SHALL hold and load_ack SHALL stay 0; a requester holding load_req across two boundaries SHALL get two captures and two acks.
REQ-019 A display frame SHALL never show mixed old/new data; updates become visible starting at digit 0.
REQ-020 Synthesis/elab SHALL reject SCAN_DIV < 2 or BLANK_CYCLES >= SCAN_DIV.

Reset
REQ-021 On rst = 1, the block SHALL immediately (asynchronously) set io_sel = 0, io_seg = 8'hFF, load_ack = 0, frame_done = 0, prescaler = 0, index = 0, shadow value = 0, shadow dp = 0, state = BLANK.
REQ-022 Reset mid-slot or mid-handshake SHALL drop any pending ack; after release, the first slot SHALL start at digit 0 with a full BLANK period.

Configuration
REQ-023 With SEG_SCAN_HEX_EN defined, nibbles 0-F SHALL decode to hex glyphs (A, b, C, d, E, F).
REQ-024 Without SEG_SCAN_HEX_EN, nibbles 0-9 SHALL decode normally and A-F SHALL decode to all segments off (7'h7F).

Structure
REQ-025 Package seg_pkg SHALL hold the FSM state enum, the active-low glyph constants 0-F and the digit count constant (4).
REQ-026 Combinational sub-module seg_decode (nibble -> 7 segments, honouring SEG_SCAN_HEX_EN) SHALL be instantiated once.

Verification (SCAN_DIV = 8, BLANK_CYCLES = 2)
REQ-027 Release reset -> io_sel = 0 / io_seg = FF for 2 cycles, then io_sel = 0001 for 6 cycles, then the sequence repeats for 0010, 0100, 1000 and wraps.
REQ-028 Hold load_req with value_in = 16'h4321, dp_in = 4'b0001 -> load_ack pulses 1 cycle after the frame_done; the next frame shows segs for 1 (dp lit), 2, 3, 4.
REQ-029 Change value_in mid-frame without load_req -> the displayed digits are unchanged, and load_ack = 0.
REQ-030 Hold load_req for 2 frames -> exactly 2 load_ack pulses, spaced 32 cycles apart.
REQ-031 Assert rst during digit 2 DRIVE with load_req high -> outputs go to reset values at once with no ack; restart shows 0000 at digit 0.
REQ-032 value_in = 16'hFEDC, both macro settings -> hex glyphs with SEG_SCAN_HEX_EN defined, blank digits without it.
